// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply / restoring divide unit with architectural HI/LO registers.
// One iteration per cycle over magnitudes, then a single sign-fix/write-back cycle.
module muldiv_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] busA,
   input  logic [WIDTH-1:0] busB,
   input  logic             flush,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

   state_t           state, next_state;
   logic [CW-1:0]    count;
   logic [WIDTH-1:0] mcand;   // multiplicand magnitude or divisor magnitude
   logic [WIDTH-1:0] ph, pl;  // product high/low, or remainder/quotient
   logic             neg_q, neg_r, is_div, dbz;

   logic             accept, is_signed, last_step;
   logic [WIDTH-1:0] mag_a, mag_b;
   logic [WIDTH:0]   mul_sum, div_shift, div_trial;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0] quo_fix, rem_fix;

   assign accept    = (state == S_IDLE) && start && !flush;
   assign is_signed = !op[0];
   assign mag_a     = (is_signed && busA[WIDTH-1]) ? -busA : busA;
   assign mag_b     = (is_signed && busB[WIDTH-1]) ? -busB : busB;
   assign last_step = (count == CW'(1));
   assign busy      = (state != S_IDLE);

   // Shift-add step: conditionally add, then shift the {ph,pl} pair right.
   assign mul_sum   = {1'b0, ph} + {1'b0, mcand & {WIDTH{pl[0]}}};
   // Restoring step: shift in the next dividend bit and trial-subtract.
   assign div_shift = {ph, pl[WIDTH-1]};
   assign div_trial = div_shift - {1'b0, mcand};

   assign prod_fix  = neg_q ? -{ph, pl} : {ph, pl};
   assign quo_fix   = dbz ? '1 : (neg_q ? -pl : pl);
   assign rem_fix   = neg_r ? -ph : ph;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= next_state;
   end

   always_comb begin
      // NOTE: next_state defaults to the current state first so no path leaves it unassigned (no latch).
      next_state = state;
      unique case (state)
         S_IDLE: if (accept) begin
            if (op == 3'b000 || op == 3'b001)      next_state = S_MUL;
            else if (op == 3'b010 || op == 3'b011) next_state = S_DIV;
         end
         S_MUL, S_DIV: begin
            if (flush)          next_state = S_IDLE;
            else if (last_step) next_state = S_FIX;
         end
         S_FIX:   next_state = S_IDLE;
         default: next_state = S_IDLE;
      endcase
   end

   // NOTE: all sequential state uses non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count       <= '0;
         mcand       <= '0;
         ph          <= '0;
         pl          <= '0;
         neg_q       <= 1'b0;
         neg_r       <= 1'b0;
         is_div      <= 1'b0;
         dbz         <= 1'b0;
         hi          <= '0;
         lo          <= '0;
         done        <= 1'b0;
         div_by_zero <= 1'b0;
      end else begin
         done        <= 1'b0;
         div_by_zero <= 1'b0;
         unique case (state)
            S_IDLE: if (accept) begin
               unique case (op)
                  3'b000, 3'b001, 3'b010, 3'b011: begin
                     is_div <= op[1];
                     mcand  <= op[1] ? mag_b : mag_a;
                     pl     <= op[1] ? mag_a : mag_b;
                     ph     <= '0;
                     count  <= CW'(WIDTH);
                     neg_q  <= is_signed && (busA[WIDTH-1] ^ busB[WIDTH-1]);
                     neg_r  <= is_signed && busA[WIDTH-1];
                     dbz    <= op[1] && (busB == '0);
                  end
                  3'b100:  hi <= busA;
                  3'b101:  lo <= busA;
                  default: ;
               endcase
            end
            S_MUL: begin
               ph    <= mul_sum[WIDTH:1];
               pl    <= {mul_sum[0], pl[WIDTH-1:1]};
               count <= count - CW'(1);
            end
            S_DIV: begin
               ph    <= div_trial[WIDTH] ? div_shift[WIDTH-1:0] : div_trial[WIDTH-1:0];
               pl    <= {pl[WIDTH-2:0], !div_trial[WIDTH]};
               count <= count - CW'(1);
            end
            S_FIX: begin
               if (is_div) begin
                  hi <= rem_fix;
                  lo <= quo_fix;
               end else begin
                  hi <= prod_fix[2*WIDTH-1:WIDTH];
                  lo <= prod_fix[WIDTH-1:0];
               end
               done        <= 1'b1;
               div_by_zero <= is_div && dbz;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: vector table, random ops against a reference
// model through a scoreboard queue, plus flush/reset/mthi/mtlo sequences.
module tb_muldiv_unit;

   localparam int W = 32;

   logic         clk, rst_n, start, flush;
   logic [2:0]   op;
   logic [W-1:0] busA, busB;
   logic         busy, done, div_by_zero;
   logic [W-1:0] hi, lo;

   muldiv_unit #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .op(op), .busA(busA), .busB(busB),
      .flush(flush), .busy(busy), .done(done), .div_by_zero(div_by_zero),
      .hi(hi), .lo(lo)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic [W-1:0] hi;
      logic [W-1:0] lo;
      logic         dbz;
   } exp_t;

   typedef struct {
      logic [2:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] hi;
      logic [W-1:0] lo;
      logic         dbz;
   } vec_t;

   exp_t sb_q[$];
   vec_t vecs[11];
   int   checks = 0;
   int   errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference model built on the simulator's own 64-bit arithmetic.
   function automatic exp_t model(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
      exp_t r;
      longint sa, sb, p;
      longint unsigned ua, ub, up;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = longint'(a);
      ub = longint'(b);
      r.dbz = 1'b0;
      r.hi  = '0;
      r.lo  = '0;
      case (o)
         3'b000: begin p = sa * sb; r.hi = p[63:32]; r.lo = p[31:0]; end
         3'b001: begin up = ua * ub; r.hi = up[63:32]; r.lo = up[31:0]; end
         default: begin
            if (b == '0) begin
               r.hi = a; r.lo = '1; r.dbz = 1'b1;
            end else if (o == 3'b010) begin
               p = sa / sb; r.lo = p[31:0];
               p = sa % sb; r.hi = p[31:0];
            end else begin
               up = ua / ub; r.lo = up[31:0];
               up = ua % ub; r.hi = up[31:0];
            end
         end
      endcase
      return r;
   endfunction

   // Called at a negedge; drives start immediately so back-to-back ops land in the done cycle.
   task automatic do_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input exp_t e, input bit flush_fix);
      int   n;
      bit   busy_ok;
      exp_t x;
      start = 1'b1; op = o; busA = a; busB = b;
      sb_q.push_back(e);
      @(negedge clk);
      start = 1'b0; busA = $urandom; busB = $urandom;
      check("busy_after_accept", 64'(busy), 64'd1);
      check("done_clears", 64'(done), 64'd0);
      n = 0;
      busy_ok = 1'b1;
      while (!done && n < 200) begin
         if (!busy) busy_ok = 1'b0;
         if (flush_fix && n == W) flush = 1'b1;
         @(negedge clk);
         flush = 1'b0;
         n++;
      end
      check("busy_held", 64'(busy_ok), 64'd1);
      check("latency", 64'(n), 64'(W + 1));
      check("busy_low_at_done", 64'(busy), 64'd0);
      x = sb_q.pop_front();
      check("hi", 64'(hi), 64'(x.hi));
      check("lo", 64'(lo), 64'(x.lo));
      check("div_by_zero", 64'(div_by_zero), 64'(x.dbz));
   endtask

   initial begin
      exp_t e;
      logic [W-1:0] prev_hi, prev_lo;
      int   cnt;

      vecs[0]  = '{3'b000, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0};
      vecs[1]  = '{3'b001, 32'hFFFFFFFD, 32'd5,        32'h00000004, 32'hFFFFFFF1, 1'b0};
      vecs[2]  = '{3'b011, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0};
      vecs[3]  = '{3'b010, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
      vecs[4]  = '{3'b010, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
      vecs[5]  = '{3'b010, 32'h00001234, 32'd0,        32'h00001234, 32'hFFFFFFFF, 1'b1};
      vecs[6]  = '{3'b011, 32'hFFFFFFFF, 32'd0,        32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1};
      vecs[7]  = '{3'b000, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
      vecs[8]  = '{3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
      vecs[9]  = '{3'b010, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
      vecs[10] = '{3'b010, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000003, 1'b0};

      rst_n = 1'b0; start = 1'b0; flush = 1'b0; op = '0; busA = '0; busB = '0;
      repeat (2) @(negedge clk);
      check("rst_hi", 64'(hi), 64'd0);
      check("rst_lo", 64'(lo), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_dbz", 64'(div_by_zero), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);

      foreach (vecs[i]) begin
         e.hi = vecs[i].hi; e.lo = vecs[i].lo; e.dbz = vecs[i].dbz;
         do_op(vecs[i].op, vecs[i].a, vecs[i].b, e, 1'b0);
      end

      for (int i = 0; i < 8; i++) begin
         logic [2:0]   o;
         logic [W-1:0] a, b;
         o = 3'($urandom_range(0, 3));
         a = $urandom;
         b = (i % 3 == 0) ? W'($urandom_range(1, 50)) : $urandom;
         do_op(o, a, b, model(o, a, b), 1'b0);
      end

      // mthi then mtlo on consecutive edges
      start = 1'b1; op = 3'b100; busA = 32'hA5A5A5A5;
      @(negedge clk);
      check("mthi_hi", 64'(hi), 64'hA5A5A5A5);
      check("mthi_busy", 64'(busy), 64'd0);
      op = 3'b101; busA = 32'h5A5A5A5A;
      @(negedge clk);
      start = 1'b0;
      check("mtlo_lo", 64'(lo), 64'h5A5A5A5A);
      check("mtlo_hi_kept", 64'(hi), 64'hA5A5A5A5);
      check("mtlo_busy", 64'(busy), 64'd0);
      check("mtlo_done", 64'(done), 64'd0);

      // reserved op is ignored
      start = 1'b1; op = 3'b111; busA = 32'h11111111;
      @(negedge clk);
      start = 1'b0;
      check("rsvd_busy", 64'(busy), 64'd0);
      check("rsvd_hi", 64'(hi), 64'hA5A5A5A5);

      // flush in the same cycle as start wins, even for mthi
      start = 1'b1; op = 3'b100; busA = 32'hDEADBEEF; flush = 1'b1;
      @(negedge clk);
      start = 1'b0; flush = 1'b0;
      check("flush_start_hi", 64'(hi), 64'hA5A5A5A5);
      check("flush_start_busy", 64'(busy), 64'd0);

      // start mult, ignored divu start at cycle 10, flush at cycle 20
      prev_hi = hi; prev_lo = lo;
      start = 1'b1; op = 3'b000; busA = 32'd1234; busB = 32'd5678;
      @(negedge clk);
      start = 1'b0;
      for (int i = 1; i <= 20; i++) begin
         start = (i == 10); op = 3'b011; busA = 32'd100; busB = 32'd7;
         @(negedge clk);
      end
      start = 1'b0;
      check("busy_before_flush", 64'(busy), 64'd1);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      check("flush_busy", 64'(busy), 64'd0);
      check("flush_done", 64'(done), 64'd0);
      check("flush_hi", 64'(hi), 64'(prev_hi));
      check("flush_lo", 64'(lo), 64'(prev_lo));
      e.hi = 32'd0; e.lo = 32'd12; e.dbz = 1'b0;
      do_op(3'b001, 32'd3, 32'd4, e, 1'b0);

      // flush during FIX does not stop the write-back
      do_op(3'b011, 32'd1000, 32'd33, model(3'b011, 32'd1000, 32'd33), 1'b1);

      // asynchronous reset for part of a cycle during DIV
      start = 1'b1; op = 3'b010; busA = 32'h1234; busB = 32'd7;
      @(negedge clk);
      start = 1'b0;
      repeat (5) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("arst_hi", 64'(hi), 64'd0);
      check("arst_lo", 64'(lo), 64'd0);
      check("arst_busy", 64'(busy), 64'd0);
      check("arst_done", 64'(done), 64'd0);
      check("arst_dbz", 64'(div_by_zero), 64'd0);
      #1 rst_n = 1'b1;
      cnt = 0;
      for (int i = 0; i < W + 5; i++) begin
         @(negedge clk);
         if (done || busy) cnt++;
      end
      check("post_reset_idle", 64'(cnt), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
